// File: rtl/ram_responder.sv
// Memory-side responder for the MAR/MDR interface: latches a level-held request,
// waits WAIT_STATES cycles, accesses a word RAM once, then holds until the strobe drops.
module ram_responder #(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [31:0]       MAR_in,
   input  logic [DATA_W-1:0] MDR_in,
   input  logic              MDR_read,
   input  logic              RAM_write,
   output logic [DATA_W-1:0] Mdata_out,
   output logic              mem_busy,
   output logic              mem_done,
   output logic              addr_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_HOLD} state_t;

   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [31:0]         addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                is_write_q, is_write_d;
   logic [DATA_W-1:0]   mdata_q, mdata_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic [DATA_W-1:0]   mem [0:(2**ADDR_W)-1];
   logic                in_range;
   logic                ram_we;

   assign in_range = (addr_q[31:ADDR_W] == '0);
   assign ram_we   = (state_q == ST_ACCESS) && is_write_q && in_range;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         is_write_q <= 1'b0;
         mdata_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         is_write_q <= is_write_d;
         mdata_q    <= mdata_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // NOTE: the RAM array has no reset; contents survive Reset and power up undefined.
   always_ff @(posedge Clock) begin
      if (ram_we) mem[addr_q[ADDR_W-1:0]] <= wdata_q;
   end

   // NOTE: every comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (RAM_write || MDR_read) begin
               state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
               cnt_d   = WAIT_LOAD;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_ACCESS;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_ACCESS: state_d = ST_HOLD;
         ST_HOLD: begin
            if (!(RAM_write || MDR_read)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      is_write_d = is_write_q;
      mdata_d    = mdata_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      mem_busy   = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            // Write wins when both strobes are high.
            if (RAM_write) begin
               addr_d     = MAR_in;
               wdata_d    = MDR_in;
               is_write_d = 1'b1;
            end else if (MDR_read) begin
               addr_d     = MAR_in;
               is_write_d = 1'b0;
            end
         end
         ST_ACCESS: begin
            done_d = 1'b1;
            err_d  = !in_range;
            if (!is_write_q) mdata_d = in_range ? mem[addr_q[ADDR_W-1:0]] : '0;
         end
         default: ;
      endcase
   end

   assign Mdata_out = mdata_q;
   assign mem_done  = done_q;
   assign addr_err  = err_q;

endmodule
